alu_instr_sequencer: RTL
========================

# alu_instr_sequencer

Hardwired control unit that sequences the CPU datapath through fetch and execute of one register-register ALU instruction per `start` request. It drives every register `out`/`in` strobe, the memory `Read` and `IncPC` controls, and the one-hot ALU operation select. Instruction fields come from the datapath's `IR` register. It takes over the role that the per-instruction datapath benches currently script by hand.

## Interface
- `RA_LSB`, 23: LSB of the 4-bit Ra field (destination) in IR.
- `RB_LSB`, 19: LSB of the 4-bit Rb field (first source).
- `RC_LSB`, 15: LSB of the 4-bit Rc field (second source).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to execute one instruction; sampled in IDLE only.
- `IR`  in  32  datapath instruction register value. Opcode is IR[31:27].
- `Rout`  out  16  one-hot GP register bus drive (bit n = Rnout).
- `Rin`  out  16  one-hot GP register load (bit n = Rnin).
- `PCout`, `MDRout`, `Zlowout`, `Zhighout`  out  1 each  bus drives.
- `PCin`, `IRin`, `MARin`, `MDRin`, `Yin`, `Zin`, `HIin`, `LOin`  out  1 each  register loads.
- `Read`, `IncPC`  out  1 each  memory read and PC increment.
- `alu_op`  out  13  one-hot ALU select, MSB→LSB: {AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT}.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in the DONE state.
- `illegal`  out  1  one-cycle pulse with `done` when the opcode is unsupported.

## Operation
- The opcode map is fixed:
  - binary ops: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011
  - MUL 01111, DIV 10000
  - unary ops: NEG 10001, NOT 10010
  - every other opcode is illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE. This is a Moore machine: all outputs decode from the registered state and the IR fields, and no output depends combinationally on `start`.
- IDLE: all outputs 0. If `start` is high, go to T0.
- T0: `PCout`, `MARin`, `IncPC`, `PCin`. Go to T1.
- T1: `Read`, `MDRin`. Go to T2.
- T2: `MDRout`, `IRin`. Go to T3.
- T3 depends on the opcode:
  - binary op: `Rout[Rb]`, `Yin`.
  - unary op: `Rout[Rb]`, `alu_op`, `Zin`.
  - MUL/DIV: `Rout[Ra]`, `Yin`.
  - illegal: no strobes, go directly to DONE with `illegal`.
- T4 depends on the opcode:
  - binary op: `Rout[Rc]`, `alu_op`, `Zin`.
  - unary op: `Zlowout`, `Rin[Ra]`, then DONE.
  - MUL/DIV: `Rout[Rb]`, `alu_op`, `Zin`.
- T5 depends on the opcode:
  - binary op: `Zlowout`, `Rin[Ra]`, then DONE.
  - MUL/DIV: `Zlowout`, `LOin`.
- T6 (MUL/DIV only): `Zhighout`, `HIin`. Go to DONE.
- DONE: `done`=1, all strobes 0. Return to IDLE.
- Bus exclusivity: at most one `*out`/`Rout` bit is high in any cycle, and `Rout`/`Rin` are strictly one-hot or zero.
- The opcode and register fields are read from `IR` from T3 onward. The value of `IR` during T0–T2 is ignored.
- `start` is ignored while `busy` is high and does not queue.

## Timing
- Reset asserted (low) forces the state to IDLE and every output to 0 immediately, asynchronously, including mid-instruction. Release is synchronous to the next rising edge.
- If `start` is high at edge k in IDLE, T0 strobes are valid for the cycle following edge k.
- Instruction length in cycles from T0 through DONE inclusive:
  - binary op: 7.
  - unary op: 6.
  - MUL/DIV: 8.
  - illegal: 5.
- `busy` rises with T0 and falls when the FSM returns to IDLE. `done` and `busy` are both high in DONE.
- Back-to-back: `start` held high gives DONE → IDLE → T0, so there is exactly one IDLE cycle between instructions.
- Ra = Rb = Rc is legal and needs no special handling; the Y and Z latches isolate the source reads from the destination write.

## Configuration
- `SEQ_MULDIV_EN`:
  - Defined: MUL/DIV follow the T3–T6 path with HI/LO writeback.
  - Undefined: opcodes 01111 and 10000 are treated as illegal, T6 and the HI/LO logic are not built, and `HIin`, `LOin` and `Zhighout` are tied to 0.

## Test plan
- `IR`=0x4A1B8000 (SHR R4,R3,R7), `start` pulse:
  - T3 gives `Rout`=0x0008 and `Yin`.
  - T4 gives `Rout`=0x0080, `alu_op`=SHR bit (0x0040) and `Zin`.
  - T5 gives `Zlowout` and `Rin`=0x0010.
  - `done` is seen 7 cycles after T0 starts.
- NOT: `IR`=0x92900000 (NOT R5,R2) → T3 gives `Rout`=0x0004 and `alu_op`=0x0001 with `Zin`, T4 gives `Rin`=0x0020, and `done` comes at cycle 6.
- MUL with `SEQ_MULDIV_EN`: `IR`=0x7A180000 (Ra=4, Rb=3) → T5 asserts `LOin`, T6 asserts `Zhighout`+`HIin`, and `done` comes at cycle 8. Without the macro: `illegal`=1 at cycle 5 and no `Rin`/`HIin`/`LOin` ever asserts.
- Opcode 11111 → `done` and `illegal` are high together at cycle 5, and `Rin`=0 throughout.
- Assert reset in T4 → all outputs 0 within the same cycle, state is IDLE, and a new `start` restarts at T0.
- `start` held high across two instructions → exactly one IDLE cycle between them, and a `start` toggled while `busy` is high has no effect.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/execute control unit for one register-register ALU instruction per start request.
// Define SEQ_MULDIV_EN to build the MUL/DIV path (T6 state and HI/LO writeback).
module alu_instr_sequencer #(
    parameter int RA_LSB = 23,
    parameter int RB_LSB = 19,
    parameter int RC_LSB = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] IR,
    output logic [15:0] Rout,
    output logic [15:0] Rin,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        Read,
    output logic        IncPC,
    output logic [12:0] alu_op,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, DONE} state_t;
    typedef enum logic [1:0] {CLS_BIN, CLS_UNARY, CLS_MULDIV, CLS_ILL} op_class_t;

    localparam logic [12:0] ALU_AND  = 13'h1000;
    localparam logic [12:0] ALU_OR   = 13'h0800;
    localparam logic [12:0] ALU_ADD  = 13'h0400;
    localparam logic [12:0] ALU_SUB  = 13'h0200;
`ifdef SEQ_MULDIV_EN
    localparam logic [12:0] ALU_MUL  = 13'h0100;
    localparam logic [12:0] ALU_DIV  = 13'h0080;
`endif
    localparam logic [12:0] ALU_SHR  = 13'h0040;
    localparam logic [12:0] ALU_SHRA = 13'h0020;
    localparam logic [12:0] ALU_SHL  = 13'h0010;
    localparam logic [12:0] ALU_ROR  = 13'h0008;
    localparam logic [12:0] ALU_ROL  = 13'h0004;
    localparam logic [12:0] ALU_NEG  = 13'h0002;
    localparam logic [12:0] ALU_NOT  = 13'h0001;

    state_t      state, next_state;
    op_class_t   op_class;
    logic [12:0] op_sel;
    logic        ill_q;
    logic [15:0] ra_hot, rb_hot, rc_hot;
    logic        unused_ir_bits;

    assign unused_ir_bits = ^IR;
    assign ra_hot = 16'd1 << IR[RA_LSB +: 4];
    assign rb_hot = 16'd1 << IR[RB_LSB +: 4];
    assign rc_hot = 16'd1 << IR[RC_LSB +: 4];

    // Opcode decode into an execution class and the one-hot ALU select.
    always_comb begin
        op_class = CLS_ILL;
        op_sel   = '0;
        case (IR[31:27])
            5'b00011: begin op_class = CLS_BIN;    op_sel = ALU_ADD;  end
            5'b00100: begin op_class = CLS_BIN;    op_sel = ALU_SUB;  end
            5'b00101: begin op_class = CLS_BIN;    op_sel = ALU_AND;  end
            5'b00110: begin op_class = CLS_BIN;    op_sel = ALU_OR;   end
            5'b00111: begin op_class = CLS_BIN;    op_sel = ALU_ROR;  end
            5'b01000: begin op_class = CLS_BIN;    op_sel = ALU_ROL;  end
            5'b01001: begin op_class = CLS_BIN;    op_sel = ALU_SHR;  end
            5'b01010: begin op_class = CLS_BIN;    op_sel = ALU_SHRA; end
            5'b01011: begin op_class = CLS_BIN;    op_sel = ALU_SHL;  end
`ifdef SEQ_MULDIV_EN
            5'b01111: begin op_class = CLS_MULDIV; op_sel = ALU_MUL;  end
            5'b10000: begin op_class = CLS_MULDIV; op_sel = ALU_DIV;  end
`endif
            5'b10001: begin op_class = CLS_UNARY;  op_sel = ALU_NEG;  end
            5'b10010: begin op_class = CLS_UNARY;  op_sel = ALU_NOT;  end
            default:  ;
        endcase
    end

    // The illegal flag is captured at T3 so the DONE pulse does not depend on IR still being valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ill_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == T3) ill_q <= (op_class == CLS_ILL);
        end
    end

    always_comb begin
        next_state = state;
        Rout     = '0;
        Rin      = '0;
        PCout    = 1'b0;
        MDRout   = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Read     = 1'b0;
        IncPC    = 1'b0;
        alu_op   = '0;
        case (state)
            IDLE: if (start) next_state = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
                next_state = T1;
            end
            T1: begin
                Read = 1'b1; MDRin = 1'b1;
                next_state = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                next_state = T3;
            end
            T3: begin
                next_state = T4;
                case (op_class)
                    CLS_BIN:    begin Rout = rb_hot; Yin = 1'b1; end
                    CLS_UNARY:  begin Rout = rb_hot; alu_op = op_sel; Zin = 1'b1; end
`ifdef SEQ_MULDIV_EN
                    CLS_MULDIV: begin Rout = ra_hot; Yin = 1'b1; end
`endif
                    default:    next_state = DONE;
                endcase
            end
            T4: begin
                next_state = DONE;
                case (op_class)
                    CLS_BIN:    begin Rout = rc_hot; alu_op = op_sel; Zin = 1'b1; next_state = T5; end
                    CLS_UNARY:  begin Zlowout = 1'b1; Rin = ra_hot; end
`ifdef SEQ_MULDIV_EN
                    CLS_MULDIV: begin Rout = rb_hot; alu_op = op_sel; Zin = 1'b1; next_state = T5; end
`endif
                    default:    ;
                endcase
            end
            T5: begin
                next_state = DONE;
                case (op_class)
                    CLS_BIN:    begin Zlowout = 1'b1; Rin = ra_hot; end
`ifdef SEQ_MULDIV_EN
                    CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; next_state = T6; end
`endif
                    default:    ;
                endcase
            end
`ifdef SEQ_MULDIV_EN
            T6: begin
                Zhighout = 1'b1; HIin = 1'b1;
                next_state = DONE;
            end
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign illegal = (state == DONE) && ill_q;

endmodule
